// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC device-side bus sequencer.
package gpmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        RD_REQ,
        RD_HOLD,
        WR_DATA,
        WR_REQ,
        DONE
    } gpmc_state_e;

    localparam logic [15:0] RD_ERR_DATA_DEFAULT = 16'hDEAD;

    function automatic int CS_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpmc_pin_sync.sv
// Two-flop synchronizer for a bundle of asynchronous pins, with rise/fall
// pulses derived from the synchronized value.
module gpmc_pin_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/gpmc_bus_sequencer.sv
// Decodes synchronized GPMC chip-select accesses into single requests on the
// internal register bus, stalling the host through gpmc_wait until completion.
module gpmc_bus_sequencer
    import gpmc_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 16,
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    CS_COUNT        = 8,
    parameter int                    TIMEOUT_CYCLES  = 255,
    parameter int                    WAIT_ACTIVE_LOW = 1,
    parameter logic [DATA_WIDTH-1:0] RD_ERR_DATA     = DATA_WIDTH'(RD_ERR_DATA_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         gpmc_addr,
    input  logic [DATA_WIDTH-1:0]         gpmc_data_i,
    output logic [DATA_WIDTH-1:0]         gpmc_data_o,
    output logic                          gpmc_data_oe,
    input  logic [CS_COUNT-1:0]           gpmc_cs_n,
    input  logic                          gpmc_adv_n,
    input  logic                          gpmc_oe_n,
    input  logic                          gpmc_we_n,
    input  logic [1:0]                    gpmc_be_n,
    output logic                          gpmc_wait,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [CS_IDX_W(CS_COUNT)-1:0] bus_cs,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wdata,
    output logic [1:0]                    bus_be,
    input  logic                          bus_ack,
    input  logic [DATA_WIDTH-1:0]         bus_rdata,
    output logic                          err_timeout,
    output logic                          err_multi_cs
);

    localparam int CS_W     = CS_IDX_W(CS_COUNT);
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CTRL_W   = CS_COUNT + 3;
    localparam int DSYNC_W  = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CTRL_W-1:0]  ctrl_s, ctrl_rise, ctrl_fall;
    logic [DSYNC_W-1:0] dsync_s, dsync_rise, dsync_fall;

    gpmc_pin_sync #(
        .WIDTH   (CTRL_W),
        .RST_VAL ({CTRL_W{1'b1}})
    ) u_ctrl_sync (
        .clk  (clk),
        .rst  (rst),
        .d    ({gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n}),
        .q    (ctrl_s),
        .rise (ctrl_rise),
        .fall (ctrl_fall)
    );

    gpmc_pin_sync #(
        .WIDTH   (DSYNC_W),
        .RST_VAL ('0)
    ) u_data_sync (
        .clk  (clk),
        .rst  (rst),
        .d    ({gpmc_addr, gpmc_data_i, gpmc_be_n}),
        .q    (dsync_s),
        .rise (dsync_rise),
        .fall (dsync_fall)
    );

    logic [CS_COUNT-1:0]   cs_n_s;
    logic                  adv_n_s, oe_n_s, we_n_s;
    logic                  cs_fall_any, adv_fall, we_rise;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_i_s;
    logic [1:0]            be_n_s;
    logic                  unused_edges;

    assign cs_n_s       = ctrl_s[CTRL_W-1:3];
    assign adv_n_s      = ctrl_s[2];
    assign oe_n_s       = ctrl_s[1];
    assign we_n_s       = ctrl_s[0];
    assign cs_fall_any  = |ctrl_fall[CTRL_W-1:3];
    assign adv_fall     = ctrl_fall[2];
    assign we_rise      = ctrl_rise[0];
    assign addr_s       = dsync_s[DSYNC_W-1:DATA_WIDTH+2];
    assign data_i_s     = dsync_s[DATA_WIDTH+1:2];
    assign be_n_s       = dsync_s[1:0];
    assign unused_edges = ^{ctrl_rise[CTRL_W-1:1], ctrl_fall[1:0], dsync_rise, dsync_fall};

    // Lowest-numbered active chip select wins; any second one flags a conflict.
    logic [CS_W-1:0] enc_idx;
    logic            enc_found, enc_multi;

    always_comb begin
        enc_idx   = '0;
        enc_found = 1'b0;
        enc_multi = 1'b0;
        for (int unsigned i = 0; i < CS_COUNT; i++) begin
            if (!cs_n_s[i]) begin
                if (enc_found) begin
                    enc_multi = 1'b1;
                end else begin
                    enc_idx   = CS_W'(i);
                    enc_found = 1'b1;
                end
            end
        end
    end

    gpmc_state_e           state_q, state_d;
    logic [CS_W-1:0]       bus_cs_q, bus_cs_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] data_o_q, data_o_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_to_q, err_to_d;
    logic                  err_multi_q, err_multi_d;
    logic                  cs_sel_n;
    logic                  stall;

    assign cs_sel_n = cs_n_s[bus_cs_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_cs_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            data_o_q    <= '0;
            cnt_q       <= '0;
            err_to_q    <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_cs_q    <= bus_cs_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            data_o_q    <= data_o_d;
            cnt_q       <= cnt_d;
            err_to_q    <= err_to_d;
            err_multi_q <= err_multi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_cs_d    = bus_cs_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        data_o_d    = data_o_q;
        cnt_d       = cnt_q;
        err_to_d    = err_to_q;
        err_multi_d = err_multi_q;
        case (state_q)
            IDLE: begin
                if (cs_fall_any) begin
                    state_d  = ADDR;
                    bus_cs_d = enc_idx;
                    if (enc_multi) err_multi_d = 1'b1;
                end
            end
            ADDR: begin
                if (cs_sel_n) begin
                    state_d = IDLE;
                end else if (adv_n_s) begin
                    bus_addr_d = addr_s;
                    bus_be_d   = ~be_n_s;
                    state_d    = STROBE;
                end
            end
            STROBE: begin
                if (!oe_n_s) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                end else if (!we_n_s) begin
                    state_d = WR_DATA;
                end else if (cs_sel_n) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (bus_ack) begin
                    data_o_d = bus_rdata;
                    state_d  = RD_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    data_o_d = RD_ERR_DATA;
                    err_to_d = 1'b1;
                    state_d  = RD_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_HOLD: begin
                if (oe_n_s) state_d = DONE;
            end
            WR_DATA: begin
                if (we_rise) begin
                    bus_wdata_d = data_i_s;
                    cnt_d       = '0;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ: begin
                if (bus_ack) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (cs_sel_n) begin
                    state_d = IDLE;
                end else if (adv_fall) begin
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        gpmc_data_oe = 1'b0;
        case (state_q)
            RD_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
            end
            WR_DATA: stall = 1'b1;
            WR_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                bus_we  = 1'b1;
            end
            RD_HOLD: gpmc_data_oe = 1'b1;
            default: ;
        endcase
    end

    assign gpmc_wait    = (WAIT_ACTIVE_LOW != 0) ? ~stall : stall;
    assign gpmc_data_o  = data_o_q;
    assign bus_cs       = bus_cs_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_be       = bus_be_q;
    assign err_timeout  = err_to_q;
    assign err_multi_cs = err_multi_q;

endmodule

// File: tb/tb_gpmc_bus_sequencer.sv
// Bench: a GPMC host driver and a bus responder, checked against a
// transaction-level model of the expected bus requests and host-visible results.
module tb_gpmc_bus_sequencer;

    localparam int TIMEOUT = 255;

    logic        clk, rst;
    logic [15:0] gpmc_addr, gpmc_data_i, gpmc_data_o;
    logic        gpmc_data_oe;
    logic [7:0]  gpmc_cs_n;
    logic        gpmc_adv_n, gpmc_oe_n, gpmc_we_n;
    logic [1:0]  gpmc_be_n;
    logic        gpmc_wait;
    logic        bus_req, bus_we;
    logic [2:0]  bus_cs;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  bus_be;
    logic        bus_ack;
    logic        err_timeout, err_multi_cs;

    gpmc_bus_sequencer #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (16),
        .CS_COUNT        (8),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .WAIT_ACTIVE_LOW (1),
        .RD_ERR_DATA     (16'hDEAD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gpmc_addr    (gpmc_addr),
        .gpmc_data_i  (gpmc_data_i),
        .gpmc_data_o  (gpmc_data_o),
        .gpmc_data_oe (gpmc_data_oe),
        .gpmc_cs_n    (gpmc_cs_n),
        .gpmc_adv_n   (gpmc_adv_n),
        .gpmc_oe_n    (gpmc_oe_n),
        .gpmc_we_n    (gpmc_we_n),
        .gpmc_be_n    (gpmc_be_n),
        .gpmc_wait    (gpmc_wait),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_cs       (bus_cs),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .err_timeout  (err_timeout),
        .err_multi_cs (err_multi_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic host_stalled;
    assign host_stalled = (gpmc_wait == 1'b0);

    typedef struct {
        logic [2:0]  cs;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } req_t;

    req_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          req_seen = 0;
    int          exp_req_total = 0;
    logic        exp_to = 1'b0;
    logic        exp_multi = 1'b0;
    int          resp_delay = 0;
    bit          resp_noack = 0;
    bit          resp_abort = 0;
    logic [15:0] resp_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lowest_low(input logic [7:0] csn);
        for (int i = 0; i < 8; i++) if (!csn[i]) return i;
        return 0;
    endfunction

    function automatic int count_low(input logic [7:0] csn);
        int c = 0;
        for (int i = 0; i < 8; i++) if (!csn[i]) c++;
        return c;
    endfunction

    // Bus responder: checks each request against the model, then acks after resp_delay.
    initial begin
        req_t        e;
        logic        changed;
        int          n;
        logic [2:0]  c_cs;
        logic [15:0] c_addr, c_wdata;
        logic [1:0]  c_be;
        logic        c_we;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                req_seen++;
                check_eq("pending_reqs", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("req_cs", bus_cs, e.cs);
                    check_eq("req_we", bus_we, e.we);
                    check_eq("req_addr", bus_addr, e.addr);
                    check_eq("req_be", bus_be, e.be);
                    if (e.we) check_eq("req_wdata", bus_wdata, e.wdata);
                end
                c_cs = bus_cs; c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
                changed = 1'b0;
                n = 0;
                while (n < 300) begin
                    if (!resp_noack && n == resp_delay) begin
                        bus_rdata = resp_rdata;
                        bus_ack   = 1'b1;
                        check_eq("stall_at_ack", host_stalled, 1);
                        @(negedge clk);
                        bus_ack   = 1'b0;
                        bus_rdata = 16'($urandom);
                        check_eq("req_drop_after_ack", bus_req, 0);
                        check_eq("wait_release_after_ack", host_stalled, 0);
                        break;
                    end
                    @(negedge clk);
                    n++;
                    if (bus_req !== 1'b1) break;
                    if (bus_cs !== c_cs || bus_addr !== c_addr || bus_wdata !== c_wdata ||
                        bus_be !== c_be || bus_we !== c_we) changed = 1'b1;
                end
                check_eq("req_fields_stable", changed, 0);
                if (resp_noack && !resp_abort) check_eq("timeout_req_cycles", n, TIMEOUT);
            end
        end
    end

    task automatic host_access(input logic [7:0] csn, input logic [15:0] addr, input bit rd,
                               input logic [15:0] wd, input logic [1:0] ben, input int delay,
                               input bit noack, input logic [15:0] rdv, input bit keep_cs);
        req_t e;
        int   k;
        e.cs = 3'(lowest_low(csn));
        e.we = !rd;
        e.addr = addr;
        e.wdata = wd;
        e.be = ~ben;
        exp_q.push_back(e);
        exp_req_total++;
        resp_delay = delay;
        resp_noack = noack;
        resp_abort = 0;
        resp_rdata = rdv;
        if (count_low(csn) > 1) exp_multi = 1'b1;
        if (noack) exp_to = 1'b1;
        @(negedge clk);
        gpmc_cs_n = csn; gpmc_addr = addr; gpmc_be_n = ben; gpmc_adv_n = 1'b0;
        repeat (3) @(negedge clk);
        gpmc_adv_n = 1'b1;
        repeat (3) @(negedge clk);
        if (rd) begin
            gpmc_oe_n = 1'b0;
        end else begin
            gpmc_data_i = wd;
            gpmc_we_n = 1'b0;
            repeat (4) @(negedge clk);
            gpmc_we_n = 1'b1;
        end
        repeat (4) @(negedge clk);
        k = 0;
        while (host_stalled && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("host_wait_released", host_stalled, 0);
        if (rd) begin
            check_eq("rd_data_oe", gpmc_data_oe, 1);
            check_eq("rd_data", gpmc_data_o, noack ? 16'hDEAD : rdv);
            gpmc_oe_n = 1'b1;
            repeat (5) @(negedge clk);
            check_eq("rd_oe_off", gpmc_data_oe, 0);
        end else begin
            repeat (2) @(negedge clk);
            gpmc_data_i = 16'($urandom);
        end
        if (!keep_cs) begin
            gpmc_cs_n = '1;
            repeat (5) @(negedge clk);
        end
        check_eq("req_count", req_seen, exp_req_total);
        check_eq("err_timeout", err_timeout, exp_to);
        check_eq("err_multi_cs", err_multi_cs, exp_multi);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] csn;
        int         k;
        bit         keep, prev_keep;
        rst = 1'b1;
        gpmc_cs_n = '1; gpmc_adv_n = 1'b1; gpmc_oe_n = 1'b1; gpmc_we_n = 1'b1;
        gpmc_addr = '0; gpmc_data_i = '0; gpmc_be_n = '1;
        repeat (3) @(negedge clk);
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_data_oe", gpmc_data_oe, 0);
        check_eq("rst_data_o", gpmc_data_o, 0);
        check_eq("rst_wait", gpmc_wait, 1);
        check_eq("rst_bus_we", bus_we, 0);
        check_eq("rst_bus_fields", {bus_cs, bus_addr, bus_wdata, bus_be}, 0);
        check_eq("rst_errs", {err_timeout, err_multi_cs}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        host_access(8'b1111_1011, 16'h0040, 1, 16'h0000, 2'b00, 5, 0, 16'h1234, 0);
        host_access(8'b1111_1110, 16'h0010, 0, 16'hBEEF, 2'b10, 3, 0, 16'h0000, 0);
        host_access(8'b1101_1111, 16'h0100, 0, 16'h1111, 2'b00, 0, 0, 16'h0000, 1);
        host_access(8'b1101_1111, 16'h0102, 0, 16'h2222, 2'b01, 2, 0, 16'h0000, 0);
        host_access(8'b1111_0101, 16'h0200, 1, 16'h0000, 2'b00, 1, 0, 16'h5A5A, 0);

        // Chip select without a strobe must not generate a request.
        @(negedge clk);
        gpmc_cs_n = 8'b0111_1111; gpmc_adv_n = 1'b0;
        repeat (3) @(negedge clk);
        gpmc_adv_n = 1'b1;
        repeat (8) @(negedge clk);
        gpmc_cs_n = '1;
        repeat (6) @(negedge clk);
        check_eq("empty_cycle_no_req", req_seen, exp_req_total);

        host_access(8'b1111_1011, 16'h0300, 1, 16'h0000, 2'b00, 0, 1, 16'h0000, 0);
        host_access(8'b1011_1111, 16'h0304, 1, 16'h0000, 2'b00, 4, 0, 16'hC0DE, 0);

        // Reset while a read request is outstanding.
        exp_q.push_back('{cs: 3'd4, we: 1'b0, addr: 16'h0AA0, wdata: 16'h0, be: 2'b11});
        exp_req_total++;
        resp_noack = 1; resp_abort = 1;
        @(negedge clk);
        gpmc_cs_n = 8'b1110_1111; gpmc_addr = 16'h0AA0; gpmc_be_n = 2'b00; gpmc_adv_n = 1'b0;
        repeat (3) @(negedge clk);
        gpmc_adv_n = 1'b1;
        repeat (3) @(negedge clk);
        gpmc_oe_n = 1'b0;
        k = 0;
        while (bus_req !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_test_req_seen", bus_req, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1; gpmc_cs_n = '1; gpmc_oe_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_bus_req", bus_req, 0);
        check_eq("midrst_data_oe", gpmc_data_oe, 0);
        check_eq("midrst_wait", gpmc_wait, 1);
        check_eq("midrst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        exp_to = 1'b0; exp_multi = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("midrst_req_count", req_seen, exp_req_total);

        prev_keep = 0;
        csn = '1;
        for (int i = 0; i < 24; i++) begin
            if (!prev_keep) begin
                csn = '1;
                csn[$urandom_range(0, 7)] = 1'b0;
                if ($urandom_range(0, 5) == 0) csn[$urandom_range(0, 7)] = 1'b0;
            end
            keep = ($urandom_range(0, 3) == 0) && (i != 23);
            host_access(csn, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                        2'($urandom), $urandom_range(0, 12), 0, 16'($urandom), keep);
            prev_keep = keep;
        end

        repeat (5) @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("final_req_count", req_seen, exp_req_total);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
